vga_fb_writer: RTL and testbench
================================

# vga_fb_writer

Bus-side write controller for the 1-bit-per-pixel VGA frame buffer. It sits between the microprocessor data bus and port A (write port) of the dual-port frame buffer, whose port B is read by `VGA_Sig_Gen`. It turns memory-mapped register writes into clipped single-pixel writes and a hardware screen fill, and it holds the foreground/background colour word driven to `CONFIG_COLOURS`.

## Interface
Parameters:
- `BASE_ADDR`, 8'hB0: bus base address of the 8-register window.
- `FB_WIDTH`, 320: visible columns.
- `FB_HEIGHT`, 240: visible rows.

Ports:
- `CLK` in 1: system clock, 100 MHz.
- `RESET` in 1: synchronous, active-high reset.
- `BUS_ADDR` in 8: bus address.
- `BUS_DATA_IN` in 8: bus write data.
- `BUS_WE` in 1: bus write strobe, one cycle per write.
- `BUS_RE` in 1: bus read strobe.
- `BUS_DATA_OUT` out 8: read data, registered.
- `BUS_DATA_OUT_EN` out 1: high for one cycle when `BUS_DATA_OUT` is valid.
- `FB_WE` out 1: frame buffer write enable.
- `FB_ADDR` out 17: `{Y[7:0], X[8:0]}`, the same packing the VGA reader uses.
- `FB_DATA` out 1: pixel bit.
- `CONFIG_COLOURS` out 16: `{FG[7:0], BG[7:0]}`.
- `BUSY` out 1: fill in progress.

## Operation
Register map, offset from `BASE_ADDR`. Writes use `BUS_WE`; reads use `BUS_RE`.
- +0 `XLO`: X[7:0].
- +1 `XHI`: X[8] (bit0).
- +2 `Y`: Y[7:0].
- +3 `PIXEL`: a write issues a pixel write of bit0 at (X,Y).
- +4 `FG`: foreground colour.
- +5 `BG`: background colour.
- +6 `CMD`: a write with bit7=1 starts a fill using value bit0.
- +7 `STATUS` (read only): bit0 `BUSY`, bit1 sticky `DROP`, bit2 sticky `CLIP`.
- Reading +0..+6 returns the stored value; unused bits read 0.
- Addresses outside the window are ignored; `BUS_DATA_OUT_EN` stays low for them.

Pixel write:
- If X<`FB_WIDTH` and Y<`FB_HEIGHT`: issue `FB_WE`.
- Otherwise: no write, and `CLIP` is set.
- A `PIXEL` write while `BUSY`=1 is discarded, and `DROP` is set.
- X/Y and colour writes are always accepted, including during a fill.

Fill FSM:
- States: `IDLE` → `FILL` → `DONE` → `IDLE`.
- `IDLE`: a `CMD` write with bit7=1 latches the fill value and enters `FILL`.
- `FILL`: `FB_WE`=1 every cycle. Address sweeps X 0..319 inside Y 0..239, X wrapping 319→0 with Y increment.
- After (319,239) is written, go to `DONE`. `DONE` clears `BUSY` and returns to `IDLE`. Total 76800 write cycles.
- A `CMD` write during `FILL` is ignored; no restart.

`STATUS` read clears `DROP` and `CLIP` in the same cycle the data is captured. A flag that sets in that same cycle stays set.

Reset mid-fill: FSM returns to `IDLE` immediately and `FB_WE` deasserts the next edge. Partially filled memory is left as is.

## Timing
Reset values:
- `FB_WE`=0, `FB_ADDR`=0, `FB_DATA`=0, `BUSY`=0.
- `BUS_DATA_OUT`=0, `BUS_DATA_OUT_EN`=0.
- X=Y=0, `DROP`=`CLIP`=0.
- `CONFIG_COLOURS`=16'hFF00 (white on black).

Latencies:
- `PIXEL` write in cycle n → `FB_WE`/`FB_ADDR`/`FB_DATA` valid in cycle n+1, for exactly one cycle.
- `CMD` write in cycle n → `BUSY`=1 and first fill write (addr 0) in cycle n+1. Last fill write in cycle n+76800; `BUSY`=0 in cycle n+76801.
- `BUS_RE` in cycle n → `BUS_DATA_OUT` and `BUS_DATA_OUT_EN` valid in cycle n+1.
- Colour register write in cycle n → `CONFIG_COLOURS` updates in cycle n+1.
- All outputs are registered.

## Configuration
- `VGA_FB_FILL_EN` defined: fill engine, `CMD` register and `BUSY` are present as described.
- Not defined: no FSM is built. `CMD` writes are ignored and read back as 0. `BUSY` and `STATUS` bit0 are tied 0, and `DROP` never sets.

## Structure
- Shared package `vga_pkg`:
  - Register offset constants.
  - `FB_WIDTH`/`FB_HEIGHT` defaults.
  - Address-packing function `{y[7:0], x[8:0]}`.
  - Fill FSM state enum.
- Sub-modules: two instances of the existing `Generic_counter` (widths 9/max 319 and 8/max 239, column trigger enabling the row counter) form the fill address generator. No other sub-module.

## Test plan
- Reset, then read +4, +5, +7 → `8'hFF`, `8'h00`, `8'h00`, each with `BUS_DATA_OUT_EN` one cycle after `BUS_RE`.
- Write X=319 (+0=`8'h3F`, +1=`8'h01`), Y=239, `PIXEL`=1 → next cycle `FB_WE`=1, `FB_ADDR`={8'd239,9'd319}, `FB_DATA`=1.
- Write X=320, `PIXEL`=1 → no `FB_WE`. `STATUS` read returns `8'h04`; a second read returns `8'h00`.
- `CMD`=`8'h81` → `BUSY` high for 76800 cycles, every address written once with `FB_DATA`=1. A `PIXEL` write mid-fill → `DROP` set, and no write outside the sweep sequence.
- Assert `RESET` at fill cycle 1000 → `FB_WE`=0 and `BUSY`=0 the next cycle. A new `CMD` then restarts from address 0.
- Write `FG`=`8'hE0`, `BG`=`8'h03` → `CONFIG_COLOURS`=`16'hE003` one cycle after the second write.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame buffer write path: register offsets,
// default screen size, frame buffer address packing and fill FSM states.
package vga_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;

  localparam logic [2:0] REG_XLO    = 3'd0;
  localparam logic [2:0] REG_XHI    = 3'd1;
  localparam logic [2:0] REG_Y      = 3'd2;
  localparam logic [2:0] REG_PIXEL  = 3'd3;
  localparam logic [2:0] REG_FG     = 3'd4;
  localparam logic [2:0] REG_BG     = 3'd5;
  localparam logic [2:0] REG_CMD    = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fillState_e;

  // Same {row, column} packing the VGA reader uses on port B.
  function automatic logic [16:0] fbPack(input logic [7:0] y, input logic [8:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/Generic_counter.sv
// Wrapping up-counter; trigOut_o pulses combinationally while enabled at the
// maximum count so it can cascade into the enable of a following counter.
module Generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  output logic                     trigOut_o,
  output logic [COUNTER_WIDTH-1:0] count_o
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_L = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      if (count_q == MAX_L) count_d = '0;
      else                  count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign trigOut_o = enable_i && (count_q == MAX_L);
  assign count_o   = count_q;

endmodule

// File: rtl/vga_fb_writer.sv
// Bus-side write controller for the 1bpp VGA frame buffer: clipped pixel
// writes, colour word, and (with VGA_FB_FILL_EN defined) a hardware screen fill.
module vga_fb_writer
  import vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         FB_WIDTH  = FB_WIDTH_DEF,
  parameter int         FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA_IN,
  input  logic        BUS_WE,
  input  logic        BUS_RE,
  output logic [7:0]  BUS_DATA_OUT,
  output logic        BUS_DATA_OUT_EN,
  output logic        FB_WE,
  output logic [16:0] FB_ADDR,
  output logic        FB_DATA,
  output logic [15:0] CONFIG_COLOURS,
  output logic        BUSY
);

  localparam logic [9:0] WIDTH_L  = 10'(FB_WIDTH);
  localparam logic [8:0] HEIGHT_L = 9'(FB_HEIGHT);

  logic [8:0] addrDiff;
  logic       inWindow, wrEn, rdEn;
  logic [2:0] regOff;

  logic [7:0]  xLo_q, xLo_d, y_q, y_d, fg_q, fg_d, bg_q, bg_d;
  logic        xHi_q, xHi_d, pix_q, pix_d;
  logic        drop_q, drop_d, clip_q, clip_d;
  logic        fbWe_q, fbWe_d, fbData_q, fbData_d;
  logic [16:0] fbAddr_q, fbAddr_d;
  logic [7:0]  dataOut_q, dataOut_d;
  logic        dataOutEn_q, dataOutEn_d;
  logic        dropSet, clipSet, statusRd, pixInRange;

  logic        fillBusy, fillWe, fillVal;
  logic [16:0] fillAddr;
  logic [7:0]  cmdRead;

  // A 9-bit difference makes addresses below the base wrap out of the window.
  assign addrDiff   = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign inWindow   = (addrDiff < 9'd8);
  assign regOff     = addrDiff[2:0];
  assign wrEn       = BUS_WE && inWindow;
  assign rdEn       = BUS_RE && inWindow;
  assign pixInRange = ({1'b0, xHi_q, xLo_q} < WIDTH_L) && ({1'b0, y_q} < HEIGHT_L);

`ifdef VGA_FB_FILL_EN
  fillState_e  state_q, state_d;
  logic        busy_q, busy_d;
  logic        fillVal_q, cmdWr, fillStart, cntEn, colTrig, rowTrig;
  logic [7:0]  cmd_q;
  logic [8:0]  colCount;
  logic [7:0]  rowCount;

  assign cmdWr     = wrEn && (regOff == REG_CMD);
  assign fillStart = cmdWr && BUS_DATA_IN[7] && (state_q == ST_IDLE);
  assign cntEn     = fillStart || (state_q == ST_FILL);

  Generic_counter #(.COUNTER_WIDTH(9), .COUNTER_MAX(FB_WIDTH - 1)) colCounter (
    .clk_i(CLK), .reset_i(RESET), .enable_i(cntEn),
    .trigOut_o(colTrig), .count_o(colCount)
  );

  Generic_counter #(.COUNTER_WIDTH(8), .COUNTER_MAX(FB_HEIGHT - 1)) rowCounter (
    .clk_i(CLK), .reset_i(RESET), .enable_i(colTrig),
    .trigOut_o(rowTrig), .count_o(rowCount)
  );

  // The counters always hold the next address to present, so the start cycle
  // already emits address 0 and rowTrig marks the final pixel.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    fillWe   = 1'b0;
    fillAddr = fbPack(rowCount, colCount);
    fillVal  = fillVal_q;
    unique case (state_q)
      ST_IDLE: begin
        fillVal = BUS_DATA_IN[0];
        if (fillStart) begin
          state_d = ST_FILL;
          busy_d  = 1'b1;
          fillWe  = 1'b1;
        end
      end
      ST_FILL: begin
        fillWe = 1'b1;
        if (rowTrig) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      fillVal_q <= 1'b0;
      cmd_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (fillStart) fillVal_q <= BUS_DATA_IN[0];
      if (cmdWr && !busy_q) cmd_q <= BUS_DATA_IN;
    end
  end

  assign fillBusy = busy_q;
  assign cmdRead  = cmd_q;
`else
  assign fillBusy = 1'b0;
  assign fillWe   = 1'b0;
  assign fillAddr = 17'd0;
  assign fillVal  = 1'b0;
  assign cmdRead  = 8'h00;
`endif

  // Bus decode: register writes, clipped pixel writes, reads and sticky flags.
  always_comb begin
    xLo_d       = xLo_q;
    xHi_d       = xHi_q;
    y_d         = y_q;
    pix_d       = pix_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    fbWe_d      = 1'b0;
    fbAddr_d    = fbAddr_q;
    fbData_d    = fbData_q;
    dataOut_d   = dataOut_q;
    dataOutEn_d = 1'b0;
    dropSet     = 1'b0;
    clipSet     = 1'b0;
    statusRd    = 1'b0;

    if (wrEn) begin
      unique case (regOff)
        REG_XLO: xLo_d = BUS_DATA_IN;
        REG_XHI: xHi_d = BUS_DATA_IN[0];
        REG_Y:   y_d   = BUS_DATA_IN;
        REG_PIXEL: begin
          pix_d = BUS_DATA_IN[0];
          if (fillBusy) begin
            dropSet = 1'b1;
          end else if (pixInRange) begin
            fbWe_d   = 1'b1;
            fbAddr_d = fbPack(y_q, {xHi_q, xLo_q});
            fbData_d = BUS_DATA_IN[0];
          end else begin
            clipSet = 1'b1;
          end
        end
        REG_FG:  fg_d = BUS_DATA_IN;
        REG_BG:  bg_d = BUS_DATA_IN;
        default: ;
      endcase
    end

    if (fillWe) begin
      fbWe_d   = 1'b1;
      fbAddr_d = fillAddr;
      fbData_d = fillVal;
    end

    if (rdEn) begin
      dataOutEn_d = 1'b1;
      unique case (regOff)
        REG_XLO:   dataOut_d = xLo_q;
        REG_XHI:   dataOut_d = {7'd0, xHi_q};
        REG_Y:     dataOut_d = y_q;
        REG_PIXEL: dataOut_d = {7'd0, pix_q};
        REG_FG:    dataOut_d = fg_q;
        REG_BG:    dataOut_d = bg_q;
        REG_CMD:   dataOut_d = cmdRead;
        default: begin
          dataOut_d = {5'd0, clip_q, drop_q, fillBusy};
          statusRd  = 1'b1;
        end
      endcase
    end

    // A flag raised in the same cycle as the clearing read survives it.
    drop_d = (drop_q && !statusRd) || dropSet;
    clip_d = (clip_q && !statusRd) || clipSet;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      xLo_q       <= 8'h00;
      xHi_q       <= 1'b0;
      y_q         <= 8'h00;
      pix_q       <= 1'b0;
      fg_q        <= 8'hFF;
      bg_q        <= 8'h00;
      drop_q      <= 1'b0;
      clip_q      <= 1'b0;
      fbWe_q      <= 1'b0;
      fbAddr_q    <= 17'd0;
      fbData_q    <= 1'b0;
      dataOut_q   <= 8'h00;
      dataOutEn_q <= 1'b0;
    end else begin
      xLo_q       <= xLo_d;
      xHi_q       <= xHi_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      drop_q      <= drop_d;
      clip_q      <= clip_d;
      fbWe_q      <= fbWe_d;
      fbAddr_q    <= fbAddr_d;
      fbData_q    <= fbData_d;
      dataOut_q   <= dataOut_d;
      dataOutEn_q <= dataOutEn_d;
    end
  end

  assign BUS_DATA_OUT    = dataOut_q;
  assign BUS_DATA_OUT_EN = dataOutEn_q;
  assign FB_WE           = fbWe_q;
  assign FB_ADDR         = fbAddr_q;
  assign FB_DATA         = fbData_q;
  assign CONFIG_COLOURS  = {fg_q, bg_q};
  assign BUSY            = fillBusy;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Randomized bench for vga_fb_writer against a register-level reference model;
// fill checks run only when VGA_FB_FILL_EN is defined for the build.
module tb_vga_fb_writer;

  localparam logic [7:0] BASE = 8'hB0;
  localparam int W = 320;
  localparam int H = 240;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  busAddr = 8'h00;
  logic [7:0]  busDataIn = 8'h00;
  logic        busWe = 1'b0;
  logic        busRe = 1'b0;
  logic [7:0]  busDataOut;
  logic        busDataOutEn;
  logic        fbWe;
  logic [16:0] fbAddr;
  logic        fbData;
  logic [15:0] configColours;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] mXlo, mY, mFg, mBg;
  logic       mXhi, mPix, mDrop, mClip, mBusy;

  vga_fb_writer #(.BASE_ADDR(BASE), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(busAddr), .BUS_DATA_IN(busDataIn),
    .BUS_WE(busWe), .BUS_RE(busRe), .BUS_DATA_OUT(busDataOut),
    .BUS_DATA_OUT_EN(busDataOutEn), .FB_WE(fbWe), .FB_ADDR(fbAddr),
    .FB_DATA(fbData), .CONFIG_COLOURS(configColours), .BUSY(busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mXlo = 8'h00; mXhi = 1'b0; mY = 8'h00; mPix = 1'b0;
    mFg = 8'hFF; mBg = 8'h00; mDrop = 1'b0; mClip = 1'b0; mBusy = 1'b0;
  endtask

  // Pixel index k of a full-screen sweep, as a frame buffer address.
  function automatic logic [16:0] sweepAddr(input int k);
    return 17'((k / W) * 512 + (k % W));
  endfunction

  // One bus cycle outside of a fill, checked against the model on the next cycle.
  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr, input logic [7:0] data);
    int off, xv, yv;
    bit inWin, expWe, expEn;
    logic [16:0] expAddr;
    logic [7:0] expDout;
    @(negedge CLK);
    busWe = we; busRe = re; busAddr = addr; busDataIn = data;
    off = int'(addr) - int'(BASE);
    inWin = (off >= 0) && (off < 8);
    xv = int'(mXhi) * 256 + int'(mXlo);
    yv = int'(mY);
    expWe = 0; expEn = 0; expAddr = '0; expDout = '0;
    if (we && inWin) begin
      case (off)
        0: mXlo = data;
        1: mXhi = data[0];
        2: mY = data;
        3: begin
          mPix = data[0];
          if (mBusy) mDrop = 1'b1;
          else if (xv < W && yv < H) begin expWe = 1; expAddr = 17'(yv * 512 + xv); end
          else mClip = 1'b1;
        end
        4: mFg = data;
        5: mBg = data;
        default: ;
      endcase
    end
    if (re && inWin) begin
      expEn = 1;
      case (off)
        0: expDout = mXlo;
        1: expDout = {7'd0, mXhi};
        2: expDout = mY;
        3: expDout = {7'd0, mPix};
        4: expDout = mFg;
        5: expDout = mBg;
        6: expDout = 8'h00;
        default: begin
          expDout = {5'd0, mClip, mDrop, mBusy};
          mClip = 1'b0; mDrop = 1'b0;
        end
      endcase
    end
    @(posedge CLK); #1;
    busWe = 1'b0; busRe = 1'b0;
    checkOutput("fbWe", fbWe, expWe);
    if (expWe) begin
      checkOutput("fbAddr", fbAddr, expAddr);
      checkOutput("fbData", fbData, mPix);
    end
    checkOutput("doutEn", busDataOutEn, expEn);
    if (expEn) checkOutput($sformatf("dout+%0d", off), busDataOut, expDout);
    checkOutput("colours", configColours, {mFg, mBg});
    checkOutput("busy", busy, mBusy);
  endtask

`ifdef VGA_FB_FILL_EN
  // Sweeps n fill cycles after a start; optionally pokes the bus mid-fill.
  task automatic runFill(input int n, input logic val, input bit disturb);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      busWe = 1'b0;
      checkOutput("fill", {busy, fbWe, fbData, fbAddr}, {1'b1, 1'b1, val, sweepAddr(k)});
      if (disturb) begin
        if (k == 5000) begin busWe = 1'b1; busAddr = BASE + 8'd3; busDataIn = 8'h01; mDrop = 1'b1; mPix = 1'b1; end
        if (k == 6000) begin busWe = 1'b1; busAddr = BASE + 8'd0; busDataIn = 8'h12; mXlo = 8'h12; end
        if (k == 7000) begin busWe = 1'b1; busAddr = BASE + 8'd4; busDataIn = 8'h5A; mFg = 8'h5A; end
        if (k == 7001) checkOutput("fillColours", configColours, {mFg, mBg});
        if (k == 8000) begin busWe = 1'b1; busAddr = BASE + 8'd6; busDataIn = 8'h80; end
      end
    end
  endtask

  task automatic startFill(input logic [7:0] cmd);
    @(negedge CLK);
    busWe = 1'b1; busAddr = BASE + 8'd6; busDataIn = cmd;
    mBusy = 1'b1;
  endtask
`endif

  initial begin
    int op, r;
    logic [7:0] a, d;
    resetModel();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstFbWe", fbWe, 1'b0);
    checkOutput("rstFbAddr", fbAddr, 17'd0);
    checkOutput("rstFbData", fbData, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDout", busDataOut, 8'h00);
    checkOutput("rstDoutEn", busDataOutEn, 1'b0);
    checkOutput("rstColours", configColours, 16'hFF00);
    @(negedge CLK); RESET = 1'b0;

    applyStimulus(0, 1, BASE + 8'd4, 8'h00);
    applyStimulus(0, 1, BASE + 8'd5, 8'h00);
    applyStimulus(0, 1, BASE + 8'd7, 8'h00);

    applyStimulus(1, 0, BASE + 8'd0, 8'h3F);
    applyStimulus(1, 0, BASE + 8'd1, 8'h01);
    applyStimulus(1, 0, BASE + 8'd2, 8'd239);
    applyStimulus(1, 0, BASE + 8'd3, 8'h01);

    applyStimulus(1, 0, BASE + 8'd0, 8'h40);
    applyStimulus(1, 0, BASE + 8'd3, 8'h01);
    applyStimulus(0, 1, BASE + 8'd7, 8'h00);
    applyStimulus(0, 1, BASE + 8'd7, 8'h00);

    applyStimulus(1, 0, BASE + 8'd4, 8'hE0);
    applyStimulus(1, 0, BASE + 8'd5, 8'h03);

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      d = 8'($urandom);
      if (op <= 5) begin
        applyStimulus(1, 0, BASE + 8'(op), d);
      end else if (op <= 8) begin
        applyStimulus(0, 1, BASE + 8'($urandom_range(0, 7)), d);
      end else begin
        r = $urandom_range(0, 247);
        a = (r < 8'hB0) ? 8'(r) : 8'(r + 8);
        applyStimulus(1'($urandom), 1'($urandom), a, d);
      end
    end

`ifdef VGA_FB_FILL_EN
    startFill(8'h81);
    runFill(W * H, 1'b1, 1'b1);
    @(posedge CLK); #1;
    mBusy = 1'b0;
    checkOutput("fillEndBusy", busy, 1'b0);
    checkOutput("fillEndWe", fbWe, 1'b0);
    applyStimulus(0, 1, BASE + 8'd7, 8'h00);
    applyStimulus(0, 1, BASE + 8'd0, 8'h00);

    startFill(8'h81);
    runFill(1000, 1'b1, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    resetModel();
    checkOutput("rstFillWe", fbWe, 1'b0);
    checkOutput("rstFillBusy", busy, 1'b0);
    checkOutput("rstFillColours", configColours, 16'hFF00);
    @(negedge CLK); RESET = 1'b0;
    startFill(8'h80);
    runFill(5, 1'b0, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    resetModel();
    @(negedge CLK); RESET = 1'b0;
    applyStimulus(0, 1, BASE + 8'd7, 8'h00);
`else
    applyStimulus(1, 0, BASE + 8'd6, 8'h81);
    applyStimulus(0, 0, BASE + 8'd6, 8'h00);
    applyStimulus(0, 0, BASE + 8'd6, 8'h00);
    applyStimulus(0, 1, BASE + 8'd6, 8'h00);
    applyStimulus(0, 1, BASE + 8'd7, 8'h00);
    applyStimulus(1, 0, BASE + 8'd3, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
